// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with length header and XOR checksum
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   load_start           pulse that opens a load session from IDLE, DONE or ERR
//   byte_valid/byte_data source byte stream; byte_ready marks the cycles a byte is taken
//   imem_we/addr/wdata   one-cycle word write into instruction memory
//   core_rst             registered processor reset, released only after a good load
//   done, error          load finished with good checksum / load aborted
//   words_written        words written in the current session

module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [7:0]  csum;

  logic        accept;
  logic        start;
  logic        last_word;
  logic [15:0] len_in;

  assign accept    = byte_valid & byte_ready;
  // Length as it will be once the LEN_HI byte currently on the bus is taken.
  assign len_in    = {byte_data, len_lo};
  // words_written already counts every completed word, so the word whose
  // lane-3 byte is being taken is the last one when this matches.
  assign last_word = (words_written + 16'd1) == len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          start    = 1'b1;
          state_nx = LEN0;
        end
      end
      LEN0: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_nx = LEN1;
        end
      end
      LEN1: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if ({16'd0, len_in} > DEPTH) begin
            state_nx = ERR;
          end else if (len_in == 16'd0) begin
            state_nx = CHK;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && (lane == 2'd3) && last_word) begin
          state_nx = CHK;
        end
      end
      CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_nx = (byte_data == csum) ? DONE : ERR;
        end
      end
      DONE: begin
        done = 1'b1;
        if (load_start) begin
          start    = 1'b1;
          state_nx = LEN0;
        end
      end
      ERR: begin
        error = 1'b1;
        if (load_start) begin
          start    = 1'b1;
          state_nx = LEN0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo        <= 8'd0;
      len           <= 16'd0;
      lane          <= 2'd0;
      word_buf      <= 24'd0;
      csum          <= 8'd0;
      words_written <= 16'd0;
      imem_we       <= 1'b0;
      imem_addr     <= 32'd0;
      imem_wdata    <= 32'd0;
      core_rst      <= 1'b1;
    end else begin
      imem_we  <= 1'b0;
      // Registered from the next state so it lines up with the DONE state.
      core_rst <= (state_nx != DONE);
      if (start) begin
        words_written <= 16'd0;
        lane          <= 2'd0;
        csum          <= 8'd0;
      end else if (accept) begin
        case (state)
          LEN0: begin
            len_lo <= byte_data;
            csum   <= csum ^ byte_data;
          end
          LEN1: begin
            len  <= len_in;
            csum <= csum ^ byte_data;
          end
          DATA: begin
            csum <= csum ^ byte_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                imem_we       <= 1'b1;
                imem_addr     <= BASE_ADDR + {14'd0, words_written, 2'b00};
                imem_wdata    <= {byte_data, word_buf};
                words_written <= words_written + 16'd1;
              end
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 Parameter DEPTH, default 1024: maximum number of 32-bit instruction words accepted.
REQ-003 Parameter BASE_ADDR, default 32'h0: byte address of the first written word.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load_start  input  1  single-cycle pulse that begins a load session.
REQ-007 byte_valid  input  1  source has a byte on byte_data.
REQ-008 byte_data  input  8  incoming stream byte.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 imem_addr  output  32  byte address of the word being written.
REQ-012 imem_wdata  output  32  instruction word being written.
REQ-013 core_rst  output  1  holds the processor in reset while it is asserted.
REQ-014 done  output  1  load completed with a good checksum.
REQ-015 error  output  1  load aborted (length overflow or checksum mismatch).
REQ-016 words_written  output  16  count of words written in the current session.

Function
REQ-017 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1.
REQ-018 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*4 data bytes with each word little-endian, then one CHK byte.
REQ-019 The FSM SHALL have states IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR.
REQ-020 byte_ready SHALL be 1 in LEN0, LEN1, DATA and CHK, and 0 in IDLE, DONE and ERR.
REQ-021 IDLE, DONE or ERR with load_start=1 -> LEN0; the transition SHALL clear words_written, the byte-lane counter, the running checksum, done and error.
REQ-022 LEN0 -> LEN1 on acceptance; LEN1 -> DATA on acceptance if N>0, -> CHK if N=0, -> ERR if N>DEPTH.
REQ-023 In DATA, the byte lane SHALL count 0..3 and wrap; the byte in lane k SHALL go to bits [8k+7:8k].
REQ-024 The cycle after the lane-3 byte is accepted, imem_we SHALL be 1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*words_written(before increment) and the assembled word on imem_wdata; words_written SHALL increment in that same cycle.
REQ-025 DATA -> CHK SHALL occur when the N-th word's lane-3 byte is accepted.
REQ-026 Running checksum SHALL be the XOR of every accepted byte from LEN_LO through the last data byte.
REQ-027 CHK on acceptance: byte == checksum -> DONE; otherwise -> ERR.
REQ-028 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-029 core_rst SHALL be 1 in every state except DONE, and SHALL be a registered output.
REQ-030 load_start SHALL be ignored in LEN0, LEN1, DATA and CHK; the stream has no abort except rst.
REQ-031 imem_addr arithmetic SHALL be 32-bit modulo (wraps silently).
REQ-032 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-033 While rst=1 at a clock edge, the FSM SHALL go to IDLE, core_rst=1, and byte_ready, imem_we, done, error, words_written, imem_addr and imem_wdata SHALL all be 0, regardless of mid-session state.
REQ-034 A word partially assembled when rst is asserted SHALL NOT be written.

Verification
REQ-035 One-word load: load_start; bytes 01 00 13 05 A0 00 B7 -> one imem_we with addr 0x0, wdata 0x00A00513; then done=1, core_rst=0, words_written=1.
REQ-036 Zero length: bytes 00 00 00 -> no imem_we, DONE; a bad CHK of 01 -> ERR, error=1, core_rst=1.
REQ-037 Overflow: DEPTH=4, length bytes 05 00 -> ERR right after LEN_HI, byte_ready=0, no writes.
REQ-038 Backpressure/gaps: byte_valid toggled randomly across a 3-word load at BASE_ADDR=0x100 -> writes go to 0x100, 0x104 and 0x108 with correct words, and each byte is consumed exactly once.
REQ-039 Reset mid-DATA after 2 bytes of word 1 -> IDLE with all outputs at reset values, no write; a new load_start with a full stream -> correct load.
REQ-040 Reload from DONE: load_start -> core_rst=1 and done=0 in the next cycle, and words_written=0.
